// File: rtl/inst_mem_resp_pkg.sv
// Shared widths, constants and loader state encoding for the instruction-memory responder.
package inst_mem_resp_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } ld_state_e;

endpackage

// File: rtl/inst_mem_resp_ld_byte_packer.sv
// Assembles download bytes into a little-endian 32-bit word; flags the cycle the 4th byte lands.
module inst_mem_resp_ld_byte_packer
  import inst_mem_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [INST_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [1:0] byte_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      word_o   <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      word_o   <= '0;
    end else if (byte_en) begin
      word_o[{byte_cnt, 3'b000} +: BYTE_W] <= byte_i;
      byte_cnt                             <= byte_cnt + 2'd1;
    end
  end

  // Combinational so the loader can leave COLLECT on the very cycle the last lane fills.
  assign word_valid_o = byte_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-fetch responder: combinational word fetch plus a byte-stream download engine
// that holds the front end (ld_busy_o) while it rewrites the array.
module inst_mem_resp
  import inst_mem_resp_pkg::*;
#(
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [INST_W-1:0] NOP_INST   = NOP_INST_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     inst_addr_i,
  output logic [INST_W-1:0]     inst_o,
  output logic                  inst_fault_o,
  input  logic                  ld_start_i,
  input  logic [DEPTH_LOG2-1:0] ld_base_i,
  input  logic [DEPTH_LOG2:0]   ld_len_i,
  input  logic                  ld_valid_i,
  input  logic [BYTE_W-1:0]     ld_data_i,
  output logic                  ld_ready_o,
  output logic                  ld_busy_o,
  output logic                  ld_done_o
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  ld_state_e             state;
  logic [DEPTH_LOG2-1:0] base_q;
  logic [DEPTH_LOG2:0]   len_q;
  logic [DEPTH_LOG2:0]   word_cnt;
  logic [DEPTH_LOG2:0]   word_cnt_nxt;
  logic [DEPTH_LOG2:0]   len_clamped;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [INST_W-1:0]     mem [DEPTH];

  logic              pk_clear;
  logic              pk_byte_en;
  logic [INST_W-1:0] pk_word;
  logic              pk_word_valid;

  assign pk_clear     = (state == ST_IDLE) && ld_start_i;
  assign pk_byte_en   = (state == ST_COLLECT) && ld_valid_i && ld_ready_o;
  assign word_cnt_nxt = word_cnt + CNT_ONE;
  assign len_clamped  = (ld_len_i > FULL_LEN) ? FULL_LEN : ld_len_i;
  // D-bit sum wraps naturally, so a load starting near the top continues at word 0.
  assign wr_idx       = base_q + word_cnt[DEPTH_LOG2-1:0];

  inst_mem_resp_ld_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (pk_clear),
    .byte_en      (pk_byte_en),
    .byte_i       (ld_data_i),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  // Loader FSM; handshake outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      word_cnt   <= '0;
      ld_ready_o <= 1'b0;
      ld_busy_o  <= 1'b0;
      ld_done_o  <= 1'b0;
    end else begin
      ld_done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (ld_start_i) begin
            base_q    <= ld_base_i;
            len_q     <= len_clamped;
            word_cnt  <= '0;
            ld_busy_o <= 1'b1;
            if (len_clamped == '0) begin
              state     <= ST_DONE;
              ld_done_o <= 1'b1;
            end else begin
              state      <= ST_COLLECT;
              ld_ready_o <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (pk_word_valid) begin
            state      <= ST_WRITE;
            ld_ready_o <= 1'b0;
          end
        end
        ST_WRITE: begin
          word_cnt <= word_cnt_nxt;
          if (word_cnt_nxt == len_q) begin
            state     <= ST_DONE;
            ld_done_o <= 1'b1;
          end else begin
            state      <= ST_COLLECT;
            ld_ready_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          ld_busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps contents across an aborted load.
  always_ff @(posedge clk) begin
    if (state == ST_WRITE) begin
      mem[wr_idx] <= pk_word;
    end
  end

  assign rd_idx = inst_addr_i[DEPTH_LOG2+1:2];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    inst_fault_o = 1'b0;
    inst_o       = NOP_INST;
    if ((inst_addr_i[1:0] != 2'b00) || (inst_addr_i[ADDR_W-1:DEPTH_LOG2+2] != '0)) begin
      inst_fault_o = 1'b1;
    end else if (!ld_busy_o) begin
      inst_o = mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed + randomized bench for inst_mem_resp against a word-array reference model.
module tb_inst_mem_resp;

  localparam int          D     = 12;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        inst_fault_o;
  logic        ld_start_i;
  logic [11:0] ld_base_i;
  logic [12:0] ld_len_i;
  logic        ld_valid_i;
  logic [7:0]  ld_data_i;
  logic        ld_ready_o;
  logic        ld_busy_o;
  logic        ld_done_o;

  inst_mem_resp #(.DEPTH_LOG2(D), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_addr_i  (inst_addr_i),
    .inst_o       (inst_o),
    .inst_fault_o (inst_fault_o),
    .ld_start_i   (ld_start_i),
    .ld_base_i    (ld_base_i),
    .ld_len_i     (ld_len_i),
    .ld_valid_i   (ld_valid_i),
    .ld_data_i    (ld_data_i),
    .ld_ready_o   (ld_ready_o),
    .ld_busy_o    (ld_busy_o),
    .ld_done_o    (ld_done_o)
  );

  always #5 clk = ~clk;

  logic [31:0] ref_mem [DEPTH];
  bit          ref_vld [DEPTH];
  logic [7:0]  byte_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand(input int n);
    byte_q.delete();
    repeat (n) byte_q.push_back(8'($urandom));
  endtask

  // Expected fetch result follows the address rules directly: word aligned and inside the array.
  task automatic fetch_check(input string tag, input logic [31:0] addr);
    bit fault_exp;
    inst_addr_i = addr;
    step();
    fault_exp = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    check({tag, "_fault"}, 32'(inst_fault_o), 32'(fault_exp));
    if (fault_exp) check({tag, "_inst"}, inst_o, NOP);
    else if (ref_vld[addr / 4]) check({tag, "_inst"}, inst_o, ref_mem[addr / 4]);
  endtask

  task automatic verify_all();
    for (int i = 0; i < DEPTH; i++)
      if (ref_vld[i]) fetch_check("array_word", 32'(i * 4));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(ld_ready_o), 32'd0);
    check({tag, "_busy"},  32'(ld_busy_o),  32'd0);
    check({tag, "_done"},  32'(ld_done_o),  32'd0);
  endtask

  // Streams byte_q as a load; abort_at = byte index at which reset is pulsed (-1 for none).
  task automatic do_load(input int base, input int len, input int gap, input bit poke,
                         input int abort_at);
    int          eff;
    int          k;
    logic [31:0] w;
    eff = (len > DEPTH) ? DEPTH : len;
    k   = 0;
    w   = '0;
    ld_base_i  = 12'(base);
    ld_len_i   = 13'(len);
    ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
    check("busy_after_start", 32'(ld_busy_o), 32'd1);
    if (eff == 0) begin
      check("done_len0", 32'(ld_done_o), 32'd1);
      check("ready_len0", 32'(ld_ready_o), 32'd0);
      step();
      check("done_len0_drop", 32'(ld_done_o), 32'd0);
      check("busy_len0_drop", 32'(ld_busy_o), 32'd0);
      return;
    end
    for (int wi = 0; wi < eff; wi++) begin
      for (int b = 0; b < 4; b++) begin
        if (k == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_idle_outputs("abort");
          step();
          rst_n = 1'b1;
          step();
          check_idle_outputs("after_abort");
          return;
        end
        for (int g = 0; g < gap; g++) begin
          ld_valid_i = 1'b0;
          step();
          check("ready_in_gap", 32'(ld_ready_o), 32'd1);
        end
        ld_valid_i = 1'b1;
        ld_data_i  = byte_q[k];
        w[8*b +: 8] = byte_q[k];
        k++;
        if (poke && wi == 0 && b == 2) begin
          ld_start_i = 1'b1;
          ld_base_i  = 12'd9;
          ld_len_i   = 13'd1;
        end
        #1;
        check("ready_collect", 32'(ld_ready_o), 32'd1);
        step();
        ld_valid_i = 1'b0;
        ld_start_i = 1'b0;
      end
      check("ready_write", 32'(ld_ready_o), 32'd0);
      check("done_write",  32'(ld_done_o),  32'd0);
      check("busy_write",  32'(ld_busy_o),  32'd1);
      if (wi == 0) begin
        inst_addr_i = 32'h14;
        #1;
        check("nop_during_load", inst_o, NOP);
      end
      step();
      ref_mem[(base + wi) % DEPTH] = w;
      ref_vld[(base + wi) % DEPTH] = 1'b1;
    end
    check("done_pulse", 32'(ld_done_o), 32'd1);
    check("busy_in_done", 32'(ld_busy_o), 32'd1);
    step();
    check("done_drop", 32'(ld_done_o), 32'd0);
    check("busy_drop", 32'(ld_busy_o), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    inst_addr_i = '0;
    ld_start_i  = 1'b0;
    ld_base_i   = '0;
    ld_len_i    = '0;
    ld_valid_i  = 1'b0;
    ld_data_i   = '0;
    step();
    step();
    check_idle_outputs("in_reset");
    rst_n = 1'b1;
    step();
    check_idle_outputs("post_reset");
    fetch_check("oor_fetch", 32'h0000_4000);
    check("oor_fault_const", 32'(inst_fault_o), 32'd1);
    check("oor_inst_const", inst_o, NOP);

    // Two-word load of known instructions.
    byte_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load(5, 2, 0, 1'b0, -1);
    fetch_check("two_word_a", 32'h14);
    check("two_word_a_const", inst_o, 32'h0010_0513);
    fetch_check("two_word_b", 32'h18);
    check("two_word_b_const", inst_o, 32'h0010_0093);

    // Same bytes with gaps land identically elsewhere.
    do_load(20, 2, 3, 1'b0, -1);
    fetch_check("gap_a", 32'(20 * 4));
    check("gap_a_const", inst_o, 32'h0010_0513);
    fetch_check("gap_b", 32'(21 * 4));
    check("gap_b_const", inst_o, 32'h0010_0093);

    // Random load at 9, then a zero-length load that must change nothing.
    fill_rand(12);
    do_load(9, 3, 0, 1'b0, -1);
    do_load(5, 0, 0, 1'b0, -1);
    verify_all();

    // Restart attempt mid-load is ignored.
    fill_rand(8);
    do_load(100, 2, 1, 1'b1, -1);
    verify_all();

    // Wrap around the top of the array, then a misaligned fetch.
    fill_rand(8);
    do_load(4095, 2, 0, 1'b0, -1);
    fetch_check("wrap_top", 32'h0000_3FFC);
    fetch_check("wrap_zero", 32'h0000_0000);
    fetch_check("misaligned", 32'h0000_0002);
    check("misaligned_fault_const", 32'(inst_fault_o), 32'd1);
    check("misaligned_inst_const", inst_o, NOP);

    // Randomized loads.
    for (int n = 0; n < 4; n++) begin
      int len;
      len = int'($urandom_range(1, 3));
      fill_rand(4 * len);
      do_load(int'($urandom_range(0, DEPTH - 1)), len, int'($urandom_range(0, 2)), 1'b0, -1);
    end
    verify_all();

    // Reset after one full word and two bytes of the second word.
    fill_rand(8);
    do_load(9, 2, 0, 1'b0, 6);
    verify_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
